// File: rtl/fu_issue_fifo_n_if.sv
// fu_issue_fifo_n_if: write/read lane bundle between the issue stage, the FIFO and the FUs
//   in_valid/in_data : per-lane write requests and payloads (lane i at [i*DATA_W +: DATA_W])
//   rd_en            : per-FU ready
//   squash           : flush all contents
//   out_valid/out_data : per-FU granted entry, zero payload when not valid
//   count/almost_full/full/overflow : occupancy and status
interface fu_issue_fifo_n_if #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 3,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [IN_W-1:0]         in_valid;
    logic [IN_W*DATA_W-1:0]  in_data;
    logic [OUT_W-1:0]        rd_en;
    logic                    squash;
    logic [OUT_W-1:0]        out_valid;
    logic [OUT_W*DATA_W-1:0] out_data;
    logic [CW-1:0]           count;
    logic                    almost_full;
    logic                    full;
    logic                    overflow;
    modport master (
        output in_valid, in_data, rd_en, squash,
        input  out_valid, out_data, count, almost_full, full, overflow
    );
    modport slave (
        input  in_valid, in_data, rd_en, squash,
        output out_valid, out_data, count, almost_full, full, overflow
    );
endinterface

// File: rtl/fu_issue_fifo_n.sv
// fu_issue_fifo_n: multi-lane shift-compacting issue FIFO with same-cycle write-to-read bypass
//   i_clk   : clock, all state updates on posedge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : slave side of fu_issue_fifo_n_if (write lanes, FU read lanes, squash, status)
module fu_issue_fifo_n #(
    parameter int IN_W      = 3,
    parameter int OUT_W     = 3,
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 64,
    parameter int AF_MARGIN = 0
) (
    input logic              i_clk,
    input logic              i_rst_n,
    fu_issue_fifo_n_if.slave io_bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int XW = CW + 1;
    localparam int AW = DEPTH + IN_W + OUT_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [XW-1:0]     r_count;
    logic              r_overflow;

    logic              w_en;
    logic [XW-1:0]     w_rd_cnt;
    logic [XW-1:0]     w_push;
    logic [XW-1:0]     w_pop;
    logic [XW-1:0]     w_avail_cnt;
    logic [XW-1:0]     w_rank;
    logic              w_drop;
    logic [DATA_W-1:0] w_avail [AW];
    logic [DATA_W-1:0] w_next [DEPTH];
    logic [OUT_W-1:0]        w_out_valid;
    logic [OUT_W*DATA_W-1:0] w_out_data;

    // Available entries = stored entries followed by this cycle's accepted writes;
    // slots past the end stay zero so the shifted image is zero-filled for free.
    always_comb begin
        w_en     = i_rst_n && !io_bus.squash;
        w_rd_cnt = '0;
        for (int j = 0; j < OUT_W; j++)
            w_rd_cnt = w_rd_cnt + XW'(io_bus.rd_en[j] & w_en);
        for (int k = 0; k < AW; k++)
            w_avail[k] = '0;
        for (int k = 0; k < DEPTH; k++)
            w_avail[k] = (XW'(k) < r_count) ? r_mem[k] : '0;
        w_push = '0;
        w_drop = 1'b0;
        // Accepting while count+lower < DEPTH+requested reads equals the rule
        // stated with the final pop, since pop only falls short of the requested
        // reads when everything available is drained anyway.
        for (int i = 0; i < IN_W; i++) begin
            if (w_en && io_bus.in_valid[i]) begin
                if (r_count + w_push < XW'(DEPTH) + w_rd_cnt) begin
                    w_avail[int'(r_count) + int'(w_push)] = io_bus.in_data[i*DATA_W +: DATA_W];
                    w_push = w_push + 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
        w_avail_cnt = r_count + w_push;
        w_pop       = (w_rd_cnt < w_avail_cnt) ? w_rd_cnt : w_avail_cnt;
        w_rank      = '0;
        for (int j = 0; j < OUT_W; j++) begin
            w_out_valid[j] = w_en && io_bus.rd_en[j] && (w_rank < w_avail_cnt);
            w_out_data[j*DATA_W +: DATA_W] = w_out_valid[j] ? w_avail[int'(w_rank)] : '0;
            w_rank = w_rank + XW'(io_bus.rd_en[j]);
        end
        for (int i = 0; i < DEPTH; i++)
            w_next[i] = w_avail[i + int'(w_pop)];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (io_bus.squash) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            r_count <= w_avail_cnt - w_pop;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= w_next[i];
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign io_bus.out_valid   = w_out_valid;
    assign io_bus.out_data    = w_out_data;
    assign io_bus.count       = r_count[CW-1:0];
    assign io_bus.full        = (r_count == XW'(DEPTH));
    assign io_bus.almost_full = (int'(r_count) + IN_W + AF_MARGIN > DEPTH);
    assign io_bus.overflow    = r_overflow;
endmodule

// File: tb/tb_fu_issue_fifo_n.sv
// tb_fu_issue_fifo_n: directed checks on the default FIFO plus a queue-model random run on a 4-in/2-out FIFO
module tb_fu_issue_fifo_n;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fu_issue_fifo_n_if #(.IN_W(3), .OUT_W(3), .DEPTH(8), .DATA_W(64)) ia ();
    fu_issue_fifo_n_if #(.IN_W(4), .OUT_W(2), .DEPTH(16), .DATA_W(16)) ib ();

    fu_issue_fifo_n #(.IN_W(3), .OUT_W(3), .DEPTH(8), .DATA_W(64), .AF_MARGIN(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(ia)
    );
    fu_issue_fifo_n #(.IN_W(4), .OUT_W(2), .DEPTH(16), .DATA_W(16), .AF_MARGIN(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(ib)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] q[$];
    bit m_ovf = 1'b0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic a_set(input logic [2:0] iv, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [2:0] rd, input logic sq);
        @(negedge clk);
        ia.in_valid = iv;
        ia.in_data  = {d2, d1, d0};
        ia.rd_en    = rd;
        ia.squash   = sq;
        #1;
    endtask

    // Reference: the queue plus this cycle's writes form a list; reads take from its front.
    task automatic step_b(input logic [3:0] iv, input logic [63:0] d, input logic [1:0] rd, input logic sq);
        logic [15:0] av[$];
        logic [1:0]  eov;
        logic [31:0] eod;
        int r, a, pt;
        bit drop;
        @(negedge clk);
        ib.in_valid = iv;
        ib.in_data  = d;
        ib.rd_en    = rd;
        ib.squash   = sq;
        #1;
        check("b_count", ib.count, q.size());
        check("b_af", ib.almost_full, (q.size() + 4 + 2 > 16));
        check("b_full", ib.full, (q.size() == 16));
        check("b_ovf", ib.overflow, m_ovf);
        eov  = '0;
        eod  = '0;
        drop = 1'b0;
        av   = q;
        if (!sq) begin
            r = $countones(rd);
            a = 0;
            for (int i = 0; i < 4; i++) begin
                if (iv[i]) begin
                    pt = (q.size() + a + 1 < r) ? q.size() + a + 1 : r;
                    if (q.size() + a < 16 + pt) begin
                        av.push_back(d[i*16 +: 16]);
                        a++;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (rd[j] && av.size() > 0) begin
                    eov[j] = 1'b1;
                    eod[j*16 +: 16] = av.pop_front();
                end
            end
        end
        check("b_out_valid", ib.out_valid, eov);
        check("b_out_data", ib.out_data, eod);
        if (sq) q.delete();
        else q = av;
        if (drop) m_ovf = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        ia.in_valid = 3'b111;
        ia.in_data  = {64'hAA, 64'hBB, 64'hCC};
        ia.rd_en    = 3'b111;
        ia.squash   = 1'b0;
        ib.in_valid = '0;
        ib.in_data  = '0;
        ib.rd_en    = '0;
        ib.squash   = 1'b0;
        #1;
        check("rst_out_valid", ia.out_valid, 0);
        check("rst_out_data", ia.out_data, 0);
        check("rst_count", ia.count, 0);
        check("rst_full", ia.full, 0);
        check("rst_ovf", ia.overflow, 0);
        check("rst_af", ia.almost_full, 0);
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        ia.in_valid = '0;
        ia.rd_en    = '0;
        // bypass from empty: lane0=A, lane2=B to read lanes 1 and 2
        a_set(3'b101, 64'hA, 64'h0, 64'hB, 3'b110, 1'b0);
        check("byp_count", ia.count, 0);
        check("byp_valid", ia.out_valid, 3'b110);
        check("byp_data", ia.out_data, {64'hB, 64'hA, 64'h0});
        // fill with no reads
        a_set(3'b111, 64'h10, 64'h11, 64'h12, 3'b000, 1'b0);
        check("fill_c0", ia.count, 0);
        a_set(3'b111, 64'h20, 64'h21, 64'h22, 3'b000, 1'b0);
        check("fill_c3", ia.count, 3);
        check("fill_af3", ia.almost_full, 0);
        a_set(3'b111, 64'h30, 64'h31, 64'h32, 3'b000, 1'b0);
        check("fill_c6", ia.count, 6);
        check("fill_af6", ia.almost_full, 1);
        check("fill_ovf6", ia.overflow, 0);
        // full queue, read three, write two
        a_set(3'b011, 64'hC, 64'hD, 64'h0, 3'b111, 1'b0);
        check("full_c8", ia.count, 8);
        check("full_flag", ia.full, 1);
        check("full_ovf", ia.overflow, 1);
        check("full_valid", ia.out_valid, 3'b111);
        check("full_data", ia.out_data, {64'h12, 64'h11, 64'h10});
        a_set(3'b000, 64'h0, 64'h0, 64'h0, 3'b111, 1'b0);
        check("rw_c7", ia.count, 7);
        check("rw_ovf", ia.overflow, 1);
        check("rw_data", ia.out_data, {64'h22, 64'h21, 64'h20});
        a_set(3'b001, 64'hE, 64'h0, 64'h0, 3'b000, 1'b0);
        check("pre_sq_c4", ia.count, 4);
        // squash at count 5
        a_set(3'b111, 64'h1, 64'h2, 64'h3, 3'b111, 1'b1);
        check("sq_c5", ia.count, 5);
        check("sq_valid", ia.out_valid, 0);
        check("sq_data", ia.out_data, 0);
        a_set(3'b000, 64'h0, 64'h0, 64'h0, 3'b111, 1'b0);
        check("post_sq_count", ia.count, 0);
        check("post_sq_valid", ia.out_valid, 0);
        check("post_sq_data", ia.out_data, 0);
        check("post_sq_ovf", ia.overflow, 1);
        // mid-cycle async reset at count 4
        a_set(3'b111, 64'h1, 64'h2, 64'h3, 3'b000, 1'b0);
        a_set(3'b001, 64'h4, 64'h0, 64'h0, 3'b000, 1'b0);
        a_set(3'b000, 64'h0, 64'h0, 64'h0, 3'b000, 1'b0);
        check("ar_c4", ia.count, 4);
        #1;
        rst_n    = 1'b0;
        ia.rd_en = 3'b111;
        #1;
        check("ar_count", ia.count, 0);
        check("ar_valid", ia.out_valid, 0);
        check("ar_ovf", ia.overflow, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        ia.rd_en = '0;
        a_set(3'b001, 64'h5A5A, 64'h0, 64'h0, 3'b000, 1'b0);
        check("ar_rel_c0", ia.count, 0);
        a_set(3'b000, 64'h0, 64'h0, 64'h0, 3'b001, 1'b0);
        check("ar_x_valid", ia.out_valid, 3'b001);
        check("ar_x_data", ia.out_data, {64'h0, 64'h0, 64'h5A5A});
        a_set(3'b000, 64'h0, 64'h0, 64'h0, 3'b000, 1'b0);
        check("ar_x_count", ia.count, 0);
        // almost_full threshold on the wide configuration
        step_b(4'b1111, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 2'b00, 1'b0);
        step_b(4'b1111, {16'h0203, 16'h0202, 16'h0201, 16'h0200}, 2'b00, 1'b0);
        step_b(4'b0011, {16'h0, 16'h0, 16'h0301, 16'h0300}, 2'b00, 1'b0);
        step_b(4'b0001, {16'h0, 16'h0, 16'h0, 16'h0400}, 2'b00, 1'b0);
        check("b_af_at10", ib.almost_full, 0);
        step_b(4'b0000, 64'h0, 2'b00, 1'b0);
        check("b_af_at11", ib.almost_full, 1);
        for (int n = 0; n < 10000; n++) begin
            logic [1:0] rd;
            rd = 2'($urandom);
            if ((n / 300) % 2 == 1) rd = rd & 2'($urandom) & 2'($urandom);
            step_b(4'($urandom), {$urandom, $urandom}, rd, ($urandom_range(0, 63) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fu_issue_fifo_n.md
FU_ISSUE_FIFO_N -- requirements
Module: fu_issue_fifo_n

Interface
REQ-001 SHALL have parameter IN_W, default 3: number of write lanes per cycle.
REQ-002 SHALL have parameter OUT_W, default 3: number of FU read lanes per cycle.
REQ-003 SHALL have parameter DEPTH, default 8: number of entries, legal when DEPTH >= IN_W + OUT_W.
REQ-004 SHALL have parameter DATA_W, default 64: payload bits per entry.
REQ-005 SHALL have parameter AF_MARGIN, default 0: extra free entries held back before almost_full asserts.
REQ-006 clock  input  1  single clock; all state updates on posedge.
REQ-007 reset  input  1  asynchronous, active-low (0 = in reset).
REQ-008 in_valid  input  IN_W  per-lane write request.
REQ-009 in_data  input  IN_W*DATA_W  lane i payload at bits [i*DATA_W +: DATA_W].
REQ-010 rd_en  input  OUT_W  per-FU ready; FU j accepts one entry this cycle.
REQ-011 squash  input  1  flush all contents (branch recovery).
REQ-012 out_valid  output  OUT_W  lane j carries a valid entry this cycle.
REQ-013 out_data  output  OUT_W*DATA_W  lane j payload; all zero when out_valid[j]=0.
REQ-014 count  output  $clog2(DEPTH+1)  registered occupancy.
REQ-015 almost_full  output  1  stall request to the issue stage.
REQ-016 full  output  1  count == DEPTH.
REQ-017 overflow  output  1  sticky error: at least one write was dropped.

Function
REQ-018 Queue order: oldest entry is entry 0. Valid input lanes SHALL enqueue in ascending lane index, so the lowest valid lane is the oldest, compacted with no gaps.
REQ-019 Write-then-read bypass: entries written in cycle N SHALL be readable in cycle N when older entries do not occupy all granted read lanes, giving 0-cycle latency from an empty queue.
REQ-020 Read grant: the k-th set bit of rd_en, counted from bit 0, SHALL receive the k-th oldest available entry. Available entries are the stored entries plus the accepted writes of the current cycle.
REQ-021 out_valid[j] SHALL be 1 only when rd_en[j]=1 and an entry is assigned. Read lanes with rd_en=0 SHALL output zero.
REQ-022 pop = popcount(out_valid) and push = accepted writes. Next count SHALL be count + push - pop, and remaining entries SHALL shift toward entry 0 by pop.
REQ-023 Space rule: a write is accepted only if count + (writes accepted on lower lanes) < DEPTH + pop. Excess lanes SHALL be dropped highest-index first, and overflow SHALL be set.
REQ-024 almost_full SHALL be combinational from registered count only: 1 when count + IN_W + AF_MARGIN > DEPTH. It SHALL have no dependence on in_valid or rd_en.
REQ-025 squash=1 SHALL force out_valid=0 in the same cycle and ignore in_valid. On the next edge it SHALL set count=0 and zero all entries. squash SHALL NOT clear overflow.
REQ-026 Simultaneous full queue with push and pop: writes SHALL be accepted up to the freed space in the same cycle, per REQ-023.
REQ-027 Count arithmetic SHALL be done at $clog2(DEPTH+1)+1 bits internally, with no wrap for any parameter legal per REQ-003.
REQ-028 The implementation SHALL be a shift-compacting array with no head/tail pointer wrap. Entry i SHALL hold valid data iff i < count.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clock edge, clear count, all entries, and overflow.
REQ-030 While reset=0: out_valid=0, out_data=0, count=0, full=0, overflow=0, and almost_full follows REQ-024 with count=0.
REQ-031 Writes and reads presented during reset SHALL be ignored. The first accepted write SHALL occur on the first posedge after reset returns to 1.
REQ-032 Reset asserted mid-operation SHALL discard all contents, with no partial shift committed.

Verification
REQ-033 Defaults, empty queue, in_valid=3'b101 with data A (lane 0) and B (lane 2), rd_en=3'b110 -> same cycle out_valid=3'b110 with lane 1=A and lane 2=B; next count=0.
REQ-034 Defaults, count=0, in_valid=3'b111 with rd_en=0 for 3 cycles -> count 3,6,8. Cycle 3 drops lane 2 and sets overflow=1; full=1; almost_full=1 from count=6.
REQ-035 Defaults, count=8, in_valid=3'b011, rd_en=3'b111 -> out lanes carry entries 0..2, 2 writes accepted, next count=7, overflow unchanged.
REQ-036 count=5 and squash=1 with in_valid=3'b111 and rd_en=3'b111 -> out_valid=0 that cycle; next count=0, entries zero.
REQ-037 count=4 and reset driven low between edges -> count=0 and out_valid=0 before the next posedge; after release, a write of X followed by rd_en=3'b001 returns X.
REQ-038 IN_W=4, OUT_W=2, DEPTH=16, AF_MARGIN=2: fill to count=10 -> almost_full=0; count=11 -> almost_full=1; ordering checked against a reference queue model over 10k random cycles.
